m_inputgather: RTL
==================

# m_inputgather

Parametrised successor to the midgetv input mux. It assembles a 32-bit read word from a narrow (8/16/32-bit) external Wishbone-style data port over 1, 2 or 4 beats. It also serves MIP/MIE/MSTATUS reads and SRAM reads, and drives the core's `Di` bus with the same `sa00`-steered merge as before. It sits between the EBR register file output, the external bus and the ALU input.

## Interface
- `IWIDTH`, 8: external data width; legal values 8, 16, 32. `NBEATS = 32/IWIDTH`.
- `SRAMADRWIDTH`, 0: 0 means no SRAM; nonzero enables the `Dsram` capture path.
- `TIMEOUT`, 15: max cycles waited for `ACK_I` per beat; only used with `M_INPUTGATHER_TIMEOUT_EN`.
- `clk`  in  1  single clock, all flops rising edge
- `RST_I`  in  1  reset, synchronous, active-high
- `DAT_O`  in  32  EBR output
- `DAT_I`  in  IWIDTH  external read data
- `Dsram`  in  32  SRAM read data
- `ADR_O`  in  32  core address; `[29:28]` selects 00=IO, 01=MIP, 10=MIE, 11=MSTATUS
- `sra_msb`  in  1  msb for `shADR_O = {sra_msb, ADR_O[31:1]}`
- `sa00`  in  1  main merge select
- `STB_O`  in  1  core strobe, held until the core sees an ack
- `ACK_I`  in  1  external per-beat acknowledge
- `sram_ack`  in  1  SRAM acknowledge
- `mstat`  in  2  `{mpie, mie}`
- `ie`  in  5  `{mrinstretie, mtimeincie, meie, mtie, msie}`
- `ip`  in  5  `{mrinstretip, mtimeincip, meip, mtip, msip}`
- `xSTB`  out  1  strobe to external bus, one beat at a time
- `lane`  out  2  beat index; byte/halfword lane to the external slave
- `gack`  out  1  one-cycle pulse: gathered IO word complete
- `sysregack`  out  1  combinational; `STB_O & (ADR_O[29:28] != 0)`
- `buserr`  out  1  one-cycle pulse on timeout; tied 0 without the macro
- `rDee`  out  32  captured read word
- `Di`  out  32  data to core

## Operation
- Sysreg layout, bits not listed are 0:
  - MIP: 17 `mrinstretip`, 16 `mtimeincip`, 11 `meip`, 7 `mtip`, 3 `msip`.
  - MIE: same bit positions, using the `ie` bits.
  - MSTATUS: 12 = 1, 11 = 1, 7 = `mpie`, 3 = `mie`.
- Gather FSM, states IDLE, BEAT, DONE:
  - IDLE: `STB_O & ADR_O[29:28]==00` → BEAT, `lane`←0.
  - BEAT: `xSTB`=1. On `ACK_I`, `rDee[lane*IWIDTH +: IWIDTH]` ← `DAT_I`. If `lane == NBEATS-1` → DONE, else `lane`←`lane+1` and stay in BEAT; `xSTB` stays high across beats.
  - DONE: `xSTB`=0. `gack`=1 in the first DONE cycle only. Stays in DONE until `STB_O`=0, then → IDLE, `lane`←0. This prevents re-trigger on a held strobe.
- Sysreg read: when `sysregack`=1 and the FSM is in IDLE, `rDee` ← selected sysreg on that edge. The FSM does not leave IDLE.
- SRAM read (`SRAMADRWIDTH`≠0): `sram_ack` → `rDee` ← `Dsram`. Priority when events coincide: gather capture > sysreg > SRAM.
- Merge:
  - `sa00mod` ← `gack | sram_ack | sysregack | sa00`, registered.
  - `Di = sa00mod ? (DAT_O & rDee | ~DAT_O & shADR_O) : DAT_O`.
- For IWIDTH < 32, bits of `rDee` not written by any beat keep their previous value. All beats of an access are always written.

## Timing
- Reset values: state IDLE, `lane`=0, `xSTB`=0, `gack`=0, `buserr`=0, `rDee`=0, `sa00mod`=0, timeout counter 0.
- `xSTB` is registered. It rises the cycle after the IO-address `STB_O` is sampled.
- Zero-wait slave: `gack` arrives at cycle 1 + `NBEATS` relative to `STB_O`; `rDee` is valid in the same cycle. `Di` reflects `rDee` one cycle later via `sa00mod`.
- Each wait cycle without `ACK_I` adds one cycle of latency per beat.
- `RST_I` mid-gather: the access is abandoned and there is no `gack`. The core must re-issue.
- `STB_O` dropping mid-BEAT is illegal. The FSM finishes the gather regardless.

## Configuration
- `M_INPUTGATHER_TIMEOUT_EN` defined:
  - A counter clears on every beat start and on every `ACK_I`.
  - If it reaches `TIMEOUT` in BEAT, the current and all remaining lanes load all-ones, `buserr` pulses, and the FSM → DONE with a normal `gack` in the same cycle as `buserr`.
- Macro undefined: no counter, `buserr`=0, and the FSM waits indefinitely for `ACK_I`.

## Test plan
- IWIDTH=8, slave acks immediately with bytes 0x11, 0x22, 0x33, 0x44 → `lane` 0,1,2,3; `gack` 5 cycles after `STB_O`; `rDee`=0x44332211.
- IWIDTH=16, 2 wait states before each ack, data 0xBEEF then 0xDEAD → `gack` at cycle 7; `rDee`=0xDEADBEEF; `xSTB` high cycles 1–6.
- `ADR_O[29:28]`=11, `mpie`=1, `mie`=0 → `sysregack`=1 same cycle; next cycle `rDee`=0x00001880; FSM stays IDLE.
- `STB_O` held 3 cycles after DONE, IWIDTH=32 → exactly one `gack` pulse; no second BEAT.
- `RST_I` asserted during lane 1 of an 8-bit gather → next cycle `xSTB`=0, `lane`=0, `rDee`=0; no `gack`.
- `M_INPUTGATHER_TIMEOUT_EN`, `TIMEOUT`=4, IWIDTH=8, ack on lane 0 with 0x5A, then silence → `buserr` and `gack` pulse together; `rDee`=0xFFFFFF5A.

Source files
------------

// File: rtl/m_inputgather_if.sv
// rtl/m_inputgather_if.sv - narrow external read-port bundle between m_inputgather and its slave
interface m_inputgather_if #(
    parameter int IWIDTH = 8
);
    logic              xSTB;
    logic [1:0]        lane;
    logic              ACK_I;
    logic [IWIDTH-1:0] DAT_I;

    modport master (
        output xSTB,
        output lane,
        input  ACK_I,
        input  DAT_I
    );

    modport slave (
        input  xSTB,
        input  lane,
        output ACK_I,
        output DAT_I
    );
endinterface

// File: rtl/m_inputgather.sv
// rtl/m_inputgather.sv - 32-bit read-word gatherer and Di merge; optional M_INPUTGATHER_TIMEOUT_EN
module m_inputgather #(
    parameter int IWIDTH       = 8,
    parameter int SRAMADRWIDTH = 0,
    parameter int TIMEOUT      = 15
) (
    input  logic        clk,
    input  logic        RST_I,
    input  logic [31:0] DAT_O,
    input  logic [31:0] Dsram,
    input  logic [31:0] ADR_O,
    input  logic        sra_msb,
    input  logic        sa00,
    input  logic        STB_O,
    input  logic        sram_ack,
    input  logic [1:0]  mstat,
    input  logic [4:0]  ie,
    input  logic [4:0]  ip,
    m_inputgather_if.master bus,
    output logic        gack,
    output logic        sysregack,
    output logic        buserr,
    output logic [31:0] rDee,
    output logic [31:0] Di
);
    localparam int         NBEATS    = 32 / IWIDTH;
    localparam logic [1:0] LAST_LANE = 2'(NBEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BEAT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  lane_q, lane_d;
    logic        xstb_q, xstb_d;
    logic        gack_q, gack_d;
    logic        buserr_q, buserr_d;
    logic [31:0] rdee_q, rdee_d;
    logic        sa00mod_q, sa00mod_d;
    logic [31:0] sysreg_word;
    logic [31:0] shadr;
    logic        sram_hit;
    logic        gather_cap;
    logic        unused_ok;

`ifdef M_INPUTGATHER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    assign unused_ok = &{1'b0, ADR_O[0]};
`else
    assign unused_ok = &{1'b0, ADR_O[0], (TIMEOUT > 0)};
`endif

    // Interrupt bits share one layout for MIP and MIE.
    function automatic logic [31:0] irq_word(input logic [4:0] v);
        logic [31:0] w;
        w     = '0;
        w[17] = v[4];
        w[16] = v[3];
        w[11] = v[2];
        w[7]  = v[1];
        w[3]  = v[0];
        return w;
    endfunction

    assign sysregack = STB_O & (ADR_O[29:28] != 2'b00);
    assign shadr     = {sra_msb, ADR_O[31:1]};
    assign sram_hit  = (SRAMADRWIDTH != 0) && sram_ack;

    // Select the system register addressed by ADR_O[29:28].
    always_comb begin
        sysreg_word = '0;
        case (ADR_O[29:28])
            2'b01:   sysreg_word = irq_word(ip);
            2'b10:   sysreg_word = irq_word(ie);
            2'b11:   sysreg_word = {19'd0, 2'b11, 3'd0, mstat[1], 3'd0, mstat[0], 3'd0};
            default: sysreg_word = '0;
        endcase
    end

    // Gather FSM next state plus read-word capture with gather > sysreg > SRAM priority.
    always_comb begin
        state_d    = state_q;
        lane_d     = lane_q;
        gack_d     = 1'b0;
        buserr_d   = 1'b0;
        rdee_d     = rdee_q;
        gather_cap = 1'b0;
`ifdef M_INPUTGATHER_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (STB_O && (ADR_O[29:28] == 2'b00)) begin
                    state_d = S_BEAT;
                    lane_d  = 2'd0;
`ifdef M_INPUTGATHER_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            S_BEAT: begin
                if (bus.ACK_I) begin
                    gather_cap = 1'b1;
                    rdee_d[int'(lane_q)*IWIDTH +: IWIDTH] = bus.DAT_I;
`ifdef M_INPUTGATHER_TIMEOUT_EN
                    cnt_d = '0;
`endif
                    if (lane_q == LAST_LANE) begin
                        state_d = S_DONE;
                        gack_d  = 1'b1;
                    end else begin
                        lane_d = lane_q + 2'd1;
                    end
                end
`ifdef M_INPUTGATHER_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT)) begin
                    // Slave went silent: current and later lanes read as all-ones.
                    gather_cap = 1'b1;
                    for (int b = 0; b < NBEATS; b++) begin
                        if (b >= int'(lane_q)) begin
                            rdee_d[b*IWIDTH +: IWIDTH] = '1;
                        end
                    end
                    buserr_d = 1'b1;
                    gack_d   = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`endif
            end
            S_DONE: begin
                // Wait for the core to drop its strobe so a held STB_O cannot re-trigger.
                if (!STB_O) begin
                    state_d = S_IDLE;
                    lane_d  = 2'd0;
                end
            end
            default: begin
                state_d = S_IDLE;
                lane_d  = 2'd0;
            end
        endcase

        if (!gather_cap) begin
            if ((state_q == S_IDLE) && sysregack) begin
                rdee_d = sysreg_word;
            end else if (sram_hit) begin
                rdee_d = Dsram;
            end
        end

        xstb_d    = (state_d == S_BEAT);
        sa00mod_d = gack_q | sram_ack | sysregack | sa00;
    end

    // State, capture and merge-select registers.
    always_ff @(posedge clk) begin
        if (RST_I) begin
            state_q   <= S_IDLE;
            lane_q    <= 2'd0;
            xstb_q    <= 1'b0;
            gack_q    <= 1'b0;
            buserr_q  <= 1'b0;
            rdee_q    <= '0;
            sa00mod_q <= 1'b0;
`ifdef M_INPUTGATHER_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            lane_q    <= lane_d;
            xstb_q    <= xstb_d;
            gack_q    <= gack_d;
            buserr_q  <= buserr_d;
            rdee_q    <= rdee_d;
            sa00mod_q <= sa00mod_d;
`ifdef M_INPUTGATHER_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign bus.xSTB = xstb_q;
    assign bus.lane = lane_q;
    assign gack     = gack_q;
    assign buserr   = buserr_q;
    assign rDee     = rdee_q;
    assign Di       = sa00mod_q ? ((DAT_O & rdee_q) | (~DAT_O & shadr)) : DAT_O;
endmodule
